// File: rtl/obstacle_scheduler_if.sv
// rtl/obstacle_scheduler_if.sv - control inputs and obstacle/speed/state outputs of the scheduler
interface obstacle_scheduler_if #(
    parameter int W = 10
);
    logic         frame_tick;
    logic         start;
    logic         collision;
    logic [7:0]   rng;
    logic [W-1:0] obs1_pos;
    logic [W-1:0] obs2_pos;
    logic [1:0]   obs1_type;
    logic [1:0]   obs2_type;
    logic [2:0]   speed;
    logic [1:0]   game_state;

    modport master (
        output frame_tick, start, collision, rng,
        input  obs1_pos, obs2_pos, obs1_type, obs2_type, speed, game_state
    );

    modport slave (
        input  frame_tick, start, collision, rng,
        output obs1_pos, obs2_pos, obs1_type, obs2_type, speed, game_state
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - two-slot obstacle spawner/mover with game FSM and speed ramp
module obstacle_scheduler #(
    parameter int CONV       = 0,
    parameter int MIN_GAP    = 120,
    parameter int SPEED_STEP = 256,
    parameter int MAX_SPEED  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    obstacle_scheduler_if.slave  bus
);
    localparam int W          = 10 - CONV;
    localparam int SPAWN_BASE = (1 << W) - 32;
    localparam int GAP_LIMIT  = SPAWN_BASE - MIN_GAP;
    localparam int FCW        = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
    localparam logic [FCW-1:0] FC_LAST   = FCW'(SPEED_STEP - 1);
    localparam logic [2:0]     SPEED_MAX = 3'(MAX_SPEED);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   obs1_pos_q, obs2_pos_q;
    logic [1:0]     obs1_type_q, obs2_type_q;
    logic [2:0]     speed_q;
    logic [FCW-1:0] frame_cnt_q;
    logic [3:0]     cool_q;

    logic [W-1:0]   obs1_pos_d, obs2_pos_d, spawn_pos, speed_w;
    logic [1:0]     obs1_type_d, obs2_type_d, spawn_type;
    logic [2:0]     speed_d;
    logic [FCW-1:0] frame_cnt_d;
    logic [3:0]     cool_d;
    logic           gap1_ok, gap2_ok, elig1, elig2;

    // Everything below is the result of a RUN frame tick, computed from pre-tick state.
    always_comb begin
        speed_w    = W'(speed_q);
        spawn_pos  = {{(W-5){1'b1}}, bus.rng[6:2]};
        spawn_type = (bus.rng[1:0] == 2'd3 && speed_q < 3'd2) ? 2'd0 : bus.rng[1:0];

        gap1_ok = (obs2_pos_q == '0) || (int'(obs2_pos_q) <= GAP_LIMIT);
        gap2_ok = (obs1_pos_q == '0) || (int'(obs1_pos_q) <= GAP_LIMIT);
        elig1   = (cool_q == 4'd0) && (obs1_pos_q == '0) && gap1_ok;
        elig2   = (cool_q == 4'd0) && (obs2_pos_q == '0) && gap2_ok && !elig1;

        obs1_pos_d  = obs1_pos_q;
        obs1_type_d = obs1_type_q;
        if (obs1_pos_q > speed_w) begin
            obs1_pos_d = obs1_pos_q - speed_w;
        end else if (obs1_pos_q != '0) begin
            obs1_pos_d  = '0;
            obs1_type_d = 2'd0;
        end
        if (elig1) begin
            obs1_pos_d  = spawn_pos;
            obs1_type_d = spawn_type;
        end

        obs2_pos_d  = obs2_pos_q;
        obs2_type_d = obs2_type_q;
        if (obs2_pos_q > speed_w) begin
            obs2_pos_d = obs2_pos_q - speed_w;
        end else if (obs2_pos_q != '0) begin
            obs2_pos_d  = '0;
            obs2_type_d = 2'd0;
        end
        if (elig2) begin
            obs2_pos_d  = spawn_pos;
            obs2_type_d = spawn_type;
        end

        if (elig1 || elig2) begin
            cool_d = 4'd8 + {1'b0, bus.rng[7:5]};
        end else begin
            cool_d = (cool_q == 4'd0) ? 4'd0 : cool_q - 4'd1;
        end

        speed_d     = speed_q;
        frame_cnt_d = frame_cnt_q + 1'b1;
        if (frame_cnt_q == FC_LAST) begin
            frame_cnt_d = '0;
            speed_d     = (speed_q >= SPEED_MAX) ? SPEED_MAX : speed_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            obs1_pos_q  <= '0;
            obs2_pos_q  <= '0;
            obs1_type_q <= 2'd0;
            obs2_type_q <= 2'd0;
            speed_q     <= 3'd1;
            frame_cnt_q <= '0;
            cool_q      <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (bus.start) begin
                        state_q     <= S_RUN;
                        obs1_pos_q  <= '0;
                        obs2_pos_q  <= '0;
                        obs1_type_q <= 2'd0;
                        obs2_type_q <= 2'd0;
                        speed_q     <= 3'd1;
                        frame_cnt_q <= '0;
                        cool_q      <= 4'd0;
                    end
                end
                S_RUN: begin
                    // A collision freezes the playfield exactly as it was when hit.
                    if (bus.collision) begin
                        state_q <= S_OVER;
                    end else if (bus.frame_tick) begin
                        obs1_pos_q  <= obs1_pos_d;
                        obs2_pos_q  <= obs2_pos_d;
                        obs1_type_q <= obs1_type_d;
                        obs2_type_q <= obs2_type_d;
                        speed_q     <= speed_d;
                        frame_cnt_q <= frame_cnt_d;
                        cool_q      <= cool_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.obs1_pos   = obs1_pos_q;
    assign bus.obs2_pos   = obs2_pos_q;
    assign bus.obs1_type  = obs1_type_q;
    assign bus.obs2_type  = obs2_type_q;
    assign bus.speed      = speed_q;
    assign bus.game_state = 2'(state_q);
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - directed self-checking bench for obstacle_scheduler
module tb_obstacle_scheduler;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    obstacle_scheduler_if #(.W(10)) bus ();

    obstacle_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic ft, input logic st, input logic col, input logic [7:0] r);
        @(negedge clk);
        bus.frame_tick = ft;
        bus.start      = st;
        bus.collision  = col;
        bus.rng        = r;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.collision  = 1'b0;
    endtask

    task automatic ticks(input int n, input logic [7:0] r);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, r);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        tests_run++; if (bus.game_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d expected 0", bus.game_state); end
        tests_run++; if (bus.obs1_pos !== 10'd0 || bus.obs2_pos !== 10'd0) begin tests_failed++; $display("FAIL reset_pos got %0d/%0d expected 0/0", bus.obs1_pos, bus.obs2_pos); end
        tests_run++; if (bus.obs1_type !== 2'd0 || bus.obs2_type !== 2'd0) begin tests_failed++; $display("FAIL reset_type got %0d/%0d expected 0/0", bus.obs1_type, bus.obs2_type); end
        tests_run++; if (bus.speed !== 3'd1) begin tests_failed++; $display("FAIL reset_speed got %0d expected 1", bus.speed); end
        ticks(3, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        tests_run++; if (bus.game_state !== 2'd0 || bus.obs1_pos !== 10'd0) begin tests_failed++; $display("FAIL idle_hold got state %0d pos %0d expected 0/0", bus.game_state, bus.obs1_pos); end
    endtask

    task automatic test_first_spawn();
        step(1'b0, 1'b1, 1'b0, 8'h00);
        tests_run++; if (bus.game_state !== 2'd1) begin tests_failed++; $display("FAIL start_run got %0d expected 1", bus.game_state); end
        step(1'b1, 1'b0, 1'b0, 8'h5C);
        tests_run++; if (bus.obs1_pos !== 10'd1015) begin tests_failed++; $display("FAIL spawn_pos got %0d expected 1015", bus.obs1_pos); end
        tests_run++; if (bus.obs1_type !== 2'd0) begin tests_failed++; $display("FAIL spawn_type got %0d expected 0", bus.obs1_type); end
        tests_run++; if (bus.obs2_pos !== 10'd0) begin tests_failed++; $display("FAIL spawn_single got %0d expected 0", bus.obs2_pos); end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        tests_run++; if (bus.game_state !== 2'd1 || bus.obs1_pos !== 10'd1015) begin tests_failed++; $display("FAIL start_in_run got state %0d pos %0d expected 1/1015", bus.game_state, bus.obs1_pos); end
    endtask

    task automatic test_spawn_gap();
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        tests_run++; if (bus.obs1_pos !== 10'd992) begin tests_failed++; $display("FAIL gap_spawn got %0d expected 992", bus.obs1_pos); end
        ticks(92, 8'h00);
        tests_run++; if (bus.obs1_pos !== 10'd900 || bus.obs2_pos !== 10'd0) begin tests_failed++; $display("FAIL gap_900 got %0d/%0d expected 900/0", bus.obs1_pos, bus.obs2_pos); end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        tests_run++; if (bus.obs1_pos !== 10'd899 || bus.obs2_pos !== 10'd0) begin tests_failed++; $display("FAIL gap_899 got %0d/%0d expected 899/0", bus.obs1_pos, bus.obs2_pos); end
        ticks(27, 8'h00);
        tests_run++; if (bus.obs1_pos !== 10'd872 || bus.obs2_pos !== 10'd0) begin tests_failed++; $display("FAIL gap_872 got %0d/%0d expected 872/0", bus.obs1_pos, bus.obs2_pos); end
        step(1'b1, 1'b0, 1'b0, 8'h7F);
        tests_run++; if (bus.obs1_pos !== 10'd871 || bus.obs2_pos !== 10'd1023) begin tests_failed++; $display("FAIL gap_slot2 got %0d/%0d expected 871/1023", bus.obs1_pos, bus.obs2_pos); end
        tests_run++; if (bus.obs2_type !== 2'd0) begin tests_failed++; $display("FAIL slow_bird got %0d expected 0", bus.obs2_type); end
    endtask

    task automatic test_collision();
        step(1'b1, 1'b0, 1'b1, 8'h00);
        tests_run++; if (bus.game_state !== 2'd2 || bus.obs1_pos !== 10'd871 || bus.obs2_pos !== 10'd1023) begin tests_failed++; $display("FAIL collide got state %0d pos %0d/%0d expected 2/871/1023", bus.game_state, bus.obs1_pos, bus.obs2_pos); end
        ticks(3, 8'h00);
        tests_run++; if (bus.game_state !== 2'd2 || bus.obs1_pos !== 10'd871 || bus.obs2_pos !== 10'd1023) begin tests_failed++; $display("FAIL over_hold got state %0d pos %0d/%0d expected 2/871/1023", bus.game_state, bus.obs1_pos, bus.obs2_pos); end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        tests_run++; if (bus.game_state !== 2'd1 || bus.obs1_pos !== 10'd0 || bus.obs2_pos !== 10'd0 || bus.obs2_type !== 2'd0 || bus.speed !== 3'd1) begin
            tests_failed++; $display("FAIL restart got state %0d pos %0d/%0d speed %0d expected 1/0/0/1", bus.game_state, bus.obs1_pos, bus.obs2_pos, bus.speed); end
    endtask

    task automatic test_reset_abort();
        ticks(122, 8'h00);
        tests_run++; if (bus.obs1_pos !== 10'd871 || bus.obs2_pos !== 10'd992) begin tests_failed++; $display("FAIL both_live got %0d/%0d expected 871/992", bus.obs1_pos, bus.obs2_pos); end
        rst_n = 1'b0;
        step(1'b1, 1'b1, 1'b0, 8'hFF);
        rst_n = 1'b1;
        tests_run++; if (bus.game_state !== 2'd0 || bus.obs1_pos !== 10'd0 || bus.obs2_pos !== 10'd0 || bus.speed !== 3'd1) begin
            tests_failed++; $display("FAIL run_reset got state %0d pos %0d/%0d speed %0d expected 0/0/0/1", bus.game_state, bus.obs1_pos, bus.obs2_pos, bus.speed); end
    endtask

    task automatic test_speed_ramp();
        step(1'b0, 1'b1, 1'b0, 8'h0F);
        step(1'b1, 1'b0, 1'b0, 8'h0F);
        tests_run++; if (bus.obs1_pos !== 10'd995 || bus.obs1_type !== 2'd0) begin tests_failed++; $display("FAIL ramp_spawn got %0d type %0d expected 995/0", bus.obs1_pos, bus.obs1_type); end
        ticks(254, 8'h0F);
        tests_run++; if (bus.speed !== 3'd1) begin tests_failed++; $display("FAIL speed_255 got %0d expected 1", bus.speed); end
        step(1'b1, 1'b0, 1'b0, 8'h0F);
        tests_run++; if (bus.speed !== 3'd2) begin tests_failed++; $display("FAIL speed_256 got %0d expected 2", bus.speed); end
        ticks(255, 8'h0F);
        tests_run++; if (bus.speed !== 3'd2) begin tests_failed++; $display("FAIL speed_511 got %0d expected 2", bus.speed); end
        step(1'b1, 1'b0, 1'b0, 8'h0F);
        tests_run++; if (bus.speed !== 3'd3) begin tests_failed++; $display("FAIL speed_512 got %0d expected 3", bus.speed); end
        ticks(256, 8'h0F);
        tests_run++; if (bus.speed !== 3'd4) begin tests_failed++; $display("FAIL speed_768 got %0d expected 4", bus.speed); end
        ticks(300, 8'h0F);
        tests_run++; if (bus.speed !== 3'd4) begin tests_failed++; $display("FAIL speed_sat got %0d expected 4", bus.speed); end
    endtask

    task automatic test_expire();
        int n;
        n = 0;
        while (bus.obs1_pos !== 10'd3 && n < 600) begin
            step(1'b1, 1'b0, 1'b0, 8'h0F);
            n++;
        end
        tests_run++;
        if (bus.obs1_pos !== 10'd3) begin
            tests_failed++; $display("FAIL expire_reach got %0d expected 3 within 600 ticks", bus.obs1_pos);
        end else begin
            tests_run++; if (bus.obs1_type !== 2'd3) begin tests_failed++; $display("FAIL fast_bird got %0d expected 3", bus.obs1_type); end
            step(1'b1, 1'b0, 1'b0, 8'h0F);
            tests_run++; if (bus.obs1_pos !== 10'd0 || bus.obs1_type !== 2'd0) begin tests_failed++; $display("FAIL expire got pos %0d type %0d expected 0/0", bus.obs1_pos, bus.obs1_type); end
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.collision  = 1'b0;
        bus.rng        = 8'h00;
        test_reset();
        test_first_spawn();
        test_spawn_gap();
        test_collision();
        test_reset_abort();
        test_speed_ramp();
        test_expire();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
